tcb_fc_layer_seq: RTL

//   Time-multiplexed ternary-coded fully-connected layer (N_IN -> N_OUT): out[j] = bias[j] + sum_i x[i]*w[i][j]*SCALE.

---
 rtl/tcb_fc_layer_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tcb_fc_layer_seq.sv
// Time-multiplexed ternary-coded fully-connected layer.
// One input activation is consumed per cycle and applied to all N_OUT
// accumulators in parallel. Weights and biases are loaded at runtime.
// The SCALE multiply is built from constant shifts and adds.
module tcb_fc_layer_seq #(
  parameter int N_IN  = 64,
  parameter int N_OUT = 10,
  parameter int IN_W  = 20,
  parameter int ACC_W = 27,
  parameter int W_W   = 3,
  parameter int SCALE = 59,
  parameter int RELU  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN*IN_W-1:0]       in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_OUT*ACC_W-1:0]     out_data,
  output logic                       cfg_ready,
  input  logic                       w_wr,
  input  logic [$clog2(N_IN)-1:0]    w_addr,
  input  logic [N_OUT*W_W-1:0]       w_data,
  input  logic                       b_wr,
  input  logic [$clog2(N_OUT)-1:0]   b_addr,
  input  logic signed [ACC_W-1:0]    b_data
);

  localparam int IW = $clog2(N_IN);
  localparam logic [ACC_W-1:0] SCALE_BITS = ACC_W'(SCALE);

  typedef enum logic [1:0] {IDLE, RUN, BIAS, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [IW-1:0]           idx_reg;
  logic signed [IN_W-1:0]  x_mem [N_IN];
  logic [N_OUT*W_W-1:0]    w_mem [N_IN];
  logic signed [ACC_W-1:0] b_mem [N_OUT];

  logic                    accept;
  logic                    last_idx;
  logic [N_OUT*W_W-1:0]    w_row;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] x_scaled;

  assign accept   = in_valid && in_ready;
  assign last_idx = (idx_reg == IW'(N_IN - 1));
  assign w_row    = w_mem[idx_reg];
  assign x_ext    = ACC_W'(x_mem[idx_reg]);

  // State register; reset returns straight to IDLE from any state
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    cfg_ready  = rst;
    case (state_reg)
      IDLE: begin
        in_ready  = !rst;
        cfg_ready = 1'b1;
        if (in_valid && !rst) state_next = RUN;
      end
      RUN:  if (last_idx) state_next = BIAS;
      BIAS: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        cfg_ready = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Input index walks 0..N_IN-1 during RUN
  always_ff @(posedge clk) begin
    if (rst)                    idx_reg <= '0;
    else if (accept)            idx_reg <= '0;
    else if (state_reg == RUN)  idx_reg <= idx_reg + 1'b1;
  end

  // Input vector is sampled only on the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N_IN; i++) x_mem[i] <= in_data[i*IN_W +: IN_W];
    end
  end

  // Weight/bias storage; writes only land while the block is not computing
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++)  w_mem[i] <= '0;
      for (int j = 0; j < N_OUT; j++) b_mem[j] <= '0;
    end else begin
      if (cfg_ready && w_wr && (32'(w_addr) < N_IN))  w_mem[w_addr] <= w_data;
      if (cfg_ready && b_wr && (32'(b_addr) < N_OUT)) b_mem[b_addr] <= b_data;
    end
  end

  // Current activation times SCALE, as a sum of shifted copies
  always_comb begin
    x_scaled = '0;
    for (int k = 0; k < ACC_W; k++) begin
      if (SCALE_BITS[k]) x_scaled = x_scaled + (x_ext << k);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_neuron
      logic [W_W-1:0]          code;
      logic signed [ACC_W-1:0] term;
      logic signed [ACC_W-1:0] sum;
      logic signed [ACC_W-1:0] acc_reg;
      logic signed [ACC_W-1:0] y_reg;

      assign code = w_row[gi*W_W +: W_W];
      assign sum  = acc_reg + b_mem[gi];
      assign out_data[gi*ACC_W +: ACC_W] = y_reg;

      // Signed weight code applied bit by bit; the top bit carries negative weight
      always_comb begin
        term = '0;
        for (int b = 0; b < W_W - 1; b++) begin
          if (code[b]) term = term + (x_scaled << b);
        end
        if (code[W_W-1]) term = term - (x_scaled << (W_W - 1));
      end

      // Accumulator cleared on accept, updated once per RUN cycle
      always_ff @(posedge clk) begin
        if (rst)                   acc_reg <= '0;
        else if (accept)           acc_reg <= '0;
        else if (state_reg == RUN) acc_reg <= acc_reg + term;
      end

      // Result register loaded in BIAS and held through DONE
      always_ff @(posedge clk) begin
        if (rst) y_reg <= '0;
        else if (state_reg == BIAS) y_reg <= (RELU != 0 && sum[ACC_W-1]) ? '0 : sum;
      end
    end
  endgenerate

endmodule
